// File: rtl/soa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | soa_pkg : widths and set-one log adder shared by soa_share_arb  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package soa_pkg;

   localparam int SOA_OUT_W = 20;
   localparam int SOA_M     = 11;
   localparam int SOA_TW    = SOA_OUT_W - SOA_M;

   // The LSBs of both operands set the carry-in; the low M result bits are filled with ones.
   function automatic logic [SOA_OUT_W-1:0] soa_sum(input logic [SOA_TW-1:0] a,
                                                    input logic [SOA_TW-1:0] b);
      logic                cin;
      logic [SOA_TW-1:0]   hi;
      cin = a[0] & b[0];
      hi  = {1'b0, a[SOA_TW-1:1]} + {1'b0, b[SOA_TW-1:1]} + {{(SOA_TW-1){1'b0}}, cin};
      return {hi, {SOA_M{1'b1}}};
   endfunction

endpackage
`default_nettype wire

// File: rtl/soa_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------+
// | soa_rr_pick : rotate-priority picker, first request from ptr up  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module soa_rr_pick #(
   parameter int N    = 4,
   parameter int TAGW = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [TAGW-1:0] ptr,
   input  logic            en,
   output logic [N-1:0]    gnt,
   output logic [TAGW-1:0] idx
);

   int w_pos;

   // Walk the offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      w_pos = 0;
      if (en) begin
         for (int k = N - 1; k >= 0; k--) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            if (req[w_pos]) begin
               gnt        = '0;
               gnt[w_pos] = 1'b1;
               idx        = TAGW'(w_pos);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/soa_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------+
// | soa_share_arb : round-robin share of one set-one log adder      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module soa_share_arb
   import soa_pkg::*;
#(
   parameter int N    = 4,
   parameter int M    = SOA_M,
   parameter int TW   = SOA_OUT_W - M,
   parameter int TAGW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          req_valid,
   output logic [N-1:0]          req_ready,
   input  logic [N*TW-1:0]       req_tloga,
   input  logic [N*TW-1:0]       req_tlogb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SOA_OUT_W-1:0]  out_sumlog,
   output logic [TAGW-1:0]       out_tag,
   output logic                  busy
);

   logic                  r_s1_valid;
   logic [TW-1:0]         r_s1_a;
   logic [TW-1:0]         r_s1_b;
   logic [TAGW-1:0]       r_s1_tag;
   logic                  r_out_valid;
   logic [SOA_OUT_W-1:0]  r_out_sumlog;
   logic [TAGW-1:0]       r_out_tag;
   logic [TAGW-1:0]       r_rr_ptr;

   logic                  w_s1_en;
   logic                  w_s2_en;
   logic [N-1:0]          w_gnt;
   logic [TAGW-1:0]       w_idx;
   logic                  w_acc;
   logic [TW-1:0]         w_sel_a;
   logic [TW-1:0]         w_sel_b;
   logic [TAGW-1:0]       w_nxt_ptr;

   assign w_s2_en = !r_out_valid | out_ready;
   assign w_s1_en = !r_s1_valid | w_s2_en;

   soa_rr_pick #(
      .N    (N),
      .TAGW (TAGW)
   ) u_pick (
      .req  (req_valid),
      .ptr  (r_rr_ptr),
      .en   (w_s1_en),
      .gnt  (w_gnt),
      .idx  (w_idx)
   );

   // The picker only grants valid requesters, so any grant is an accept.
   assign w_acc     = |w_gnt;
   assign w_sel_a   = req_tloga[int'(w_idx)*TW +: TW];
   assign w_sel_b   = req_tlogb[int'(w_idx)*TW +: TW];
   assign w_nxt_ptr = (w_idx == TAGW'(N - 1)) ? '0 : w_idx + TAGW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
         r_rr_ptr   <= '0;
      end else if (w_acc) begin
         r_s1_valid <= 1'b1;
         r_s1_a     <= w_sel_a;
         r_s1_b     <= w_sel_b;
         r_s1_tag   <= w_idx;
         r_rr_ptr   <= w_nxt_ptr;
      end else if (w_s2_en) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Data only moves when stage 1 has something, so an idle output stays quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_sumlog <= '0;
         r_out_tag    <= '0;
      end else if (w_s2_en) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_sumlog <= soa_sum(r_s1_a, r_s1_b);
            r_out_tag    <= r_s1_tag;
         end
      end
   end

   assign req_ready  = w_gnt;
   assign out_valid  = r_out_valid;
   assign out_sumlog = r_out_sumlog;
   assign out_tag    = r_out_tag;
   assign busy       = r_s1_valid | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_soa_share_arb.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_soa_share_arb : directed vector bench for soa_share_arb      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_soa_share_arb;

   localparam int N    = 4;
   localparam int TW   = 9;
   localparam int TAGW = 2;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*TW-1:0]   req_tloga;
   logic [N*TW-1:0]   req_tlogb;
   logic              out_valid;
   logic              out_ready;
   logic [19:0]       out_sumlog;
   logic [TAGW-1:0]   out_tag;
   logic              busy;

   int n_cmp;
   int n_bad;

   soa_share_arb #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_tloga  (req_tloga),
      .req_tlogb  (req_tlogb),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sumlog (out_sumlog),
      .out_tag    (out_tag),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [8:0]  a;
      logic [8:0]  b;
      logic [19:0] exp_sum;
   } vec_t;

   vec_t vecs[6];

   // Per-requester operands and hand-computed sums for the multi-request sequences.
   logic [8:0]  rr_a   [4];
   logic [8:0]  rr_b   [4];
   logic [19:0] rr_exp [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic set_ops(input int i, input logic [8:0] a, input logic [8:0] b);
      req_tloga[i*TW +: TW] = a;
      req_tlogb[i*TW +: TW] = b;
   endtask

   task automatic load_rr_ops();
      for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
   endtask

   int acc_cnt;

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_tloga = '0;
      req_tlogb = '0;
      out_ready = 1'b1;

      vecs[0] = '{0, 9'h1FF, 9'h001, 20'h807FF};
      vecs[1] = '{2, 9'h002, 9'h004, 20'h01FFF};
      vecs[2] = '{1, 9'h000, 9'h000, 20'h007FF};
      vecs[3] = '{3, 9'h1FF, 9'h1FF, 20'hFFFFF};
      vecs[4] = '{0, 9'h001, 9'h001, 20'h00FFF};
      vecs[5] = '{2, 9'h0AA, 9'h055, 20'h3FFFF};

      rr_a[0] = 9'h1FF; rr_b[0] = 9'h001; rr_exp[0] = 20'h807FF;
      rr_a[1] = 9'h000; rr_b[1] = 9'h000; rr_exp[1] = 20'h007FF;
      rr_a[2] = 9'h002; rr_b[2] = 9'h004; rr_exp[2] = 20'h01FFF;
      rr_a[3] = 9'h1FF; rr_b[3] = 9'h1FF; rr_exp[3] = 20'hFFFFF;

      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_sumlog",    32'(out_sumlog), 32'd0);
      check("rst_tag",       32'(out_tag),   32'd0);
      check("rst_ready",     32'(req_ready), 32'd0);
      do_reset();

      // Single requests: grant, 2-cycle latency, sum and tag.
      for (int v = 0; v < 6; v++) begin
         set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
         req_valid = 4'(1 << vecs[v].idx);
         #1;
         check("vec_ready", 32'(req_ready), 32'(1 << vecs[v].idx));
         step();
         req_valid = '0;
         check("vec_lat1_valid", 32'(out_valid), 32'd0);
         check("vec_lat1_busy",  32'(busy),      32'd1);
         step();
         check("vec_valid", 32'(out_valid),  32'd1);
         check("vec_sum",   32'(out_sumlog), 32'(vecs[v].exp_sum));
         check("vec_tag",   32'(out_tag),    32'(vecs[v].idx));
         step();
         check("vec_idle", 32'(busy), 32'd0);
      end

      // All four requesters valid: grants and results in order 0,1,2,3,0.
      do_reset();
      load_rr_ops();
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 7; k++) begin
         if (k == 5) begin
            req_valid = '0;
            #1;
         end
         if (k < 5) check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
         if (k >= 2) begin
            check("rr_valid", 32'(out_valid),  32'd1);
            check("rr_tag",   32'(out_tag),    32'((k - 2) % 4));
            check("rr_sum",   32'(out_sumlog), 32'(rr_exp[(k - 2) % 4]));
         end
         step();
      end
      check("rr_drain", 32'(out_valid), 32'd0);

      // Backpressure: out_ready low for 5 cycles with all requesters valid.
      do_reset();
      load_rr_ops();
      out_ready = 1'b0;
      req_valid = 4'hF;
      acc_cnt   = 0;
      #1;
      for (int k = 0; k < 5; k++) begin
         if ((req_ready & req_valid) != '0) acc_cnt++;
         if (k >= 2) begin
            check("bp_ready_zero", 32'(req_ready),  32'd0);
            check("bp_valid",      32'(out_valid),  32'd1);
            check("bp_tag_hold",   32'(out_tag),    32'd0);
            check("bp_sum_hold",   32'(out_sumlog), 32'(rr_exp[0]));
         end
         step();
      end
      check("bp_accepts", 32'(acc_cnt), 32'd2);
      req_valid = '0;
      out_ready = 1'b1;
      #1;
      check("bp_rel_tag0", 32'(out_tag),    32'd0);
      check("bp_rel_sum0", 32'(out_sumlog), 32'(rr_exp[0]));
      step();
      check("bp_rel_valid1", 32'(out_valid),  32'd1);
      check("bp_rel_tag1",   32'(out_tag),    32'd1);
      check("bp_rel_sum1",   32'(out_sumlog), 32'(rr_exp[1]));
      step();
      check("bp_rel_empty", 32'(out_valid), 32'd0);
      check("bp_rel_busy",  32'(busy),      32'd0);

      // Pointer wrap: after req3 is served, req1 beats req3.
      do_reset();
      load_rr_ops();
      req_valid = 4'b1000;
      #1;
      check("wrap_g3", 32'(req_ready), 32'b1000);
      step();
      req_valid = 4'b1010;
      #1;
      check("wrap_g1", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      check("wrap_tag3", 32'(out_tag),    32'd3);
      check("wrap_sum3", 32'(out_sumlog), 32'(rr_exp[3]));
      step();
      check("wrap_tag1", 32'(out_tag),    32'd1);
      check("wrap_sum1", 32'(out_sumlog), 32'(rr_exp[1]));
      step();

      // Asynchronous reset with both stages full.
      do_reset();
      load_rr_ops();
      out_ready = 1'b0;
      req_valid = 4'hF;
      step();
      step();
      step();
      check("ar_full_valid", 32'(out_valid), 32'd1);
      check("ar_full_ready", 32'(req_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid_drop", 32'(out_valid), 32'd0);
      check("ar_busy_drop",  32'(busy),      32'd0);
      req_valid = '0;
      out_ready = 1'b1;
      step();
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("ar_no_stale", 32'(out_valid), 32'd0);
      end
      req_valid = 4'hF;
      #1;
      check("ar_first_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      step();
      check("ar_new_tag", 32'(out_tag),    32'd0);
      check("ar_new_sum", 32'(out_sumlog), 32'(rr_exp[0]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
